// File: rtl/pin_pkg.sv
// Shared types and width helpers for the PIN-entry controller.
package pin_pkg;

  typedef enum logic [1:0] {
    StEntry,
    StCheck,
    StLocked
  } state_e;

  // Digit index width; kept at least 1 bit so a single-digit PIN still has a port.
  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic int unsigned tries_width(input int unsigned max_tries);
    return $clog2(max_tries + 1);
  endfunction

  function automatic int unsigned lock_cnt_width(input int unsigned lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button synchroniser stage plus rising-edge detector.
module btn_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic edge_o
);

  logic sync_q;
  logic sync_dly_q;

  // Capture the button, then keep a delayed copy for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
    end else begin
      sync_q     <= btn_i;
      sync_dly_q <= sync_q;
    end
  end

  assign edge_o = sync_q & ~sync_dly_q;

endmodule

// File: rtl/pin_entry_ctrl.sv
// PIN-entry controller: two-button digit entry, compare or capture, lockout.
module pin_entry_ctrl
  import pin_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned DIGIT_MAX   = 9,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 b_esq_i,
  input  logic                                 b_dir_i,
  input  logic                                 setup_i,
  input  logic [DIGITS*DIGIT_W-1:0]            pin_vec_i,
  output logic [DIGIT_W-1:0]                   digit_o,
  output logic [idx_width(DIGITS)-1:0]         idx_o,
  output logic [DIGITS*DIGIT_W-1:0]            new_pin_o,
  output logic                                 new_pin_vld_o,
  output logic                                 ok_o,
  output logic                                 err_o,
  output logic                                 lock_o,
  output logic [tries_width(MAX_TRIES)-1:0]    tries_left_o
);

  localparam int unsigned IW = idx_width(DIGITS);
  localparam int unsigned TW = tries_width(MAX_TRIES);
  localparam int unsigned CW = lock_cnt_width(LOCK_CYCLES);
  localparam int unsigned PW = DIGITS * DIGIT_W;

  localparam logic [DIGIT_W-1:0] DigitMax = DIGIT_W'(DIGIT_MAX);
  localparam logic [IW-1:0]      IdxLast  = IW'(DIGITS - 1);
  localparam logic [TW-1:0]      TriesMax = TW'(MAX_TRIES);
  localparam logic [CW-1:0]      LockInit = CW'(LOCK_CYCLES);

  state_e state_q, state_d;

  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [PW-1:0]      buf_q, buf_d;
  logic [PW-1:0]      new_pin_q, new_pin_d;
  logic               new_pin_vld_q, new_pin_vld_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic               lock_q, lock_d;
  logic [TW-1:0]      tries_q, tries_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic          esq_edge;
  logic          dir_edge;
  logic [TW-1:0] tries_dec;
  logic          pin_match;
  logic          lock_done;

  btn_edge u_esq_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (b_esq_i),
    .edge_o (esq_edge)
  );

  btn_edge u_dir_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (b_dir_i),
    .edge_o (dir_edge)
  );

  // Saturating decrement so the tries count can never wrap.
  assign tries_dec = (tries_q == '0) ? '0 : tries_q - TW'(1);
  assign pin_match = (buf_q == pin_vec_i);
  assign lock_done = (cnt_q <= CW'(1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEntry;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEntry: begin
        if (esq_edge && (idx_q == IdxLast)) state_d = StCheck;
      end
      StCheck: begin
        if (!setup_i && !pin_match && (tries_dec == '0)) state_d = StLocked;
        else                                             state_d = StEntry;
      end
      StLocked: begin
        if (lock_done) state_d = StEntry;
      end
      default: state_d = StEntry;
    endcase
  end

  // Next values of the registered outputs and datapath; select beats increment.
  always_comb begin
    digit_d       = digit_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    new_pin_d     = new_pin_q;
    new_pin_vld_d = 1'b0;
    ok_d          = 1'b0;
    err_d         = 1'b0;
    lock_d        = lock_q;
    tries_d       = tries_q;
    cnt_d         = cnt_q;
    case (state_q)
      StEntry: begin
        if (esq_edge) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) buf_d[i*DIGIT_W +: DIGIT_W] = digit_q;
          end
          digit_d = '0;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
        end else if (dir_edge) begin
          digit_d = (digit_q == DigitMax) ? '0 : digit_q + DIGIT_W'(1);
        end
      end
      StCheck: begin
        buf_d = '0;
        if (setup_i) begin
          new_pin_d     = buf_q;
          new_pin_vld_d = 1'b1;
          tries_d       = TriesMax;
        end else if (pin_match) begin
          ok_d    = 1'b1;
          tries_d = TriesMax;
        end else begin
          err_d   = 1'b1;
          tries_d = tries_dec;
          if (tries_dec == '0) begin
            lock_d = 1'b1;
            cnt_d  = LockInit;
          end
        end
      end
      StLocked: begin
        if (lock_done) begin
          cnt_d   = '0;
          lock_d  = 1'b0;
          tries_d = TriesMax;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q       <= '0;
      idx_q         <= '0;
      buf_q         <= '0;
      new_pin_q     <= '0;
      new_pin_vld_q <= 1'b0;
      ok_q          <= 1'b0;
      err_q         <= 1'b0;
      lock_q        <= 1'b0;
      tries_q       <= TriesMax;
      cnt_q         <= '0;
    end else begin
      digit_q       <= digit_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      new_pin_q     <= new_pin_d;
      new_pin_vld_q <= new_pin_vld_d;
      ok_q          <= ok_d;
      err_q         <= err_d;
      lock_q        <= lock_d;
      tries_q       <= tries_d;
      cnt_q         <= cnt_d;
    end
  end

  assign digit_o       = digit_q;
  assign idx_o         = idx_q;
  assign new_pin_o     = new_pin_q;
  assign new_pin_vld_o = new_pin_vld_q;
  assign ok_o          = ok_q;
  assign err_o         = err_q;
  assign lock_o        = lock_q;
  assign tries_left_o  = tries_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Bench for pin_entry_ctrl: scenario tasks plus a pulse scoreboard.
module tb_pin_entry_ctrl;

  localparam int unsigned LockCycles = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        b_esq = 1'b0;
  logic        b_dir = 1'b0;
  logic        setup = 1'b0;
  logic [15:0] pin_vec = '0;
  logic [3:0]  digit;
  logic [1:0]  idx;
  logic [15:0] new_pin;
  logic        new_pin_vld;
  logic        ok;
  logic        err;
  logic        lock;
  logic [1:0]  tries;

  int checks = 0;
  int errors = 0;

  typedef enum int {EvOk, EvErr, EvNewPin} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] pin;
    logic [1:0]  tries;
  } ev_t;

  ev_t      exp_q[$];
  ev_t      ev_m;
  ev_kind_e got_kind;
  int       lock_run = 0;
  int       lock_run_len = 0;

  pin_entry_ctrl #(
    .DIGITS      (4),
    .DIGIT_W     (4),
    .DIGIT_MAX   (9),
    .MAX_TRIES   (3),
    .LOCK_CYCLES (LockCycles)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .b_esq_i       (b_esq),
    .b_dir_i       (b_dir),
    .setup_i       (setup),
    .pin_vec_i     (pin_vec),
    .digit_o       (digit),
    .idx_o         (idx),
    .new_pin_o     (new_pin),
    .new_pin_vld_o (new_pin_vld),
    .ok_o          (ok),
    .err_o         (err),
    .lock_o        (lock),
    .tries_left_o  (tries)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every result pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (ok || err || new_pin_vld) begin
      checks++;
      if ((int'(ok) + int'(err) + int'(new_pin_vld)) != 1) begin
        errors++;
        $display("FAIL pulse_exclusive: got ok=%b err=%b vld=%b, expected one", ok, err,
                 new_pin_vld);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got ok=%b err=%b vld=%b, expected none", ok, err,
                 new_pin_vld);
      end else begin
        ev_m     = exp_q.pop_front();
        got_kind = ok ? EvOk : (err ? EvErr : EvNewPin);
        if (got_kind !== ev_m.kind) begin
          errors++;
          $display("FAIL pulse_kind: got %0d, expected %0d", got_kind, ev_m.kind);
        end
        checks++;
        if (tries !== ev_m.tries) begin
          errors++;
          $display("FAIL pulse_tries: got %0d, expected %0d", tries, ev_m.tries);
        end
        if (ev_m.kind == EvNewPin) begin
          checks++;
          if (new_pin !== ev_m.pin) begin
            errors++;
            $display("FAIL new_pin: got %h, expected %h", new_pin, ev_m.pin);
          end
        end
      end
    end
    if (lock) begin
      lock_run++;
    end else begin
      if (lock_run > 0) lock_run_len = lock_run;
      lock_run = 0;
    end
  end

  task automatic push_exp(input ev_kind_e kind, input logic [15:0] pin, input logic [1:0] t);
    ev_t e;
    e.kind  = kind;
    e.pin   = pin;
    e.tries = t;
    exp_q.push_back(e);
  endtask

  // Tasks start and end just after a falling edge.
  task automatic press(input logic e, input logic d);
    b_esq = e;
    b_dir = d;
    repeat (2) @(negedge clk);
    b_esq = 1'b0;
    b_dir = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic enter_pin(input logic [15:0] pin);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = pin[i*4 +: 4];
      repeat (int'(d)) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    b_esq = 1'b0;
    b_dir = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL rst_digit: got %0d, expected 0", digit); end
    checks++; if (idx !== 2'd0) begin errors++; $display("FAIL rst_idx: got %0d, expected 0", idx); end
    checks++; if (new_pin !== 16'h0) begin errors++; $display("FAIL rst_new_pin: got %h, expected 0000", new_pin); end
    checks++; if ({ok, err, new_pin_vld} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b, expected 000", {ok, err, new_pin_vld}); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL rst_lock: got %b, expected 0", lock); end
    checks++; if (tries !== 2'd3) begin errors++; $display("FAIL rst_tries: got %0d, expected 3", tries); end
  endtask

  task automatic test_setup();
    setup = 1'b1;
    push_exp(EvNewPin, 16'h3210, 2'd3);
    enter_pin(16'h3210);
    setup = 1'b0;
    checks++; if (new_pin !== 16'h3210) begin errors++; $display("FAIL setup_hold: got %h, expected 3210", new_pin); end
    checks++; if (idx !== 2'd0) begin errors++; $display("FAIL setup_idx: got %0d, expected 0", idx); end
  endtask

  task automatic test_correct();
    pin_vec = 16'h3210;
    push_exp(EvOk, 16'h0, 2'd3);
    for (int i = 0; i < 3; i++) begin
      repeat (i) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
    end
    repeat (3) press(1'b0, 1'b1);
    b_esq = 1'b1;
    @(negedge clk);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL ok_edge_k: got %b, expected 0", ok); end
    @(negedge clk);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL ok_edge_k1: got %b, expected 0", ok); end
    @(negedge clk);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ok_edge_k2: got %b, expected 1", ok); end
    checks++; if (idx !== 2'd0) begin errors++; $display("FAIL ok_idx: got %0d, expected 0", idx); end
    b_esq = 1'b0;
    @(negedge clk);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL ok_width: got %b, expected 0", ok); end
    repeat (2) @(negedge clk);
  endtask

  task automatic three_wrong();
    pin_vec = 16'h3210;
    for (int t = 0; t < 3; t++) begin
      push_exp(EvErr, 16'h0, 2'(2 - t));
      enter_pin(16'h0000);
    end
  endtask

  task automatic test_lockout();
    int n;
    three_wrong();
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL lock_on: got %b, expected 1", lock); end
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    b_dir = 1'b1;
    n = 0;
    while (lock && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL lock_release: got %b, expected 0", lock); end
    checks++; if (lock_run_len != LockCycles) begin errors++; $display("FAIL lock_len: got %0d, expected %0d", lock_run_len, LockCycles); end
    checks++; if (tries !== 2'd3) begin errors++; $display("FAIL lock_tries: got %0d, expected 3", tries); end
    checks++; if (idx !== 2'd0) begin errors++; $display("FAIL lock_idx: got %0d, expected 0", idx); end
    repeat (3) @(negedge clk);
    b_dir = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL lock_held_dir: got %0d, expected 0", digit); end
  endtask

  task automatic test_wrap_hold();
    do_reset();
    repeat (9) press(1'b0, 1'b1);
    checks++; if (digit !== 4'd9) begin errors++; $display("FAIL digit_max: got %0d, expected 9", digit); end
    press(1'b0, 1'b1);
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL digit_wrap: got %0d, expected 0", digit); end
    b_dir = 1'b1;
    repeat (20) @(negedge clk);
    b_dir = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (digit !== 4'd1) begin errors++; $display("FAIL digit_hold: got %0d, expected 1", digit); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (2) press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL sim_digit: got %0d, expected 0", digit); end
    checks++; if (idx !== 2'd1) begin errors++; $display("FAIL sim_idx: got %0d, expected 1", idx); end
    setup = 1'b1;
    push_exp(EvNewPin, 16'h0002, 2'd3);
    repeat (3) press(1'b1, 1'b0);
    setup = 1'b0;
  endtask

  task automatic test_mid_reset();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    checks++; if (idx !== 2'd2) begin errors++; $display("FAIL mid_idx_pre: got %0d, expected 2", idx); end
    do_reset();
    checks++; if ({digit, idx} !== 6'd0) begin errors++; $display("FAIL mid_rst_pos: got %h, expected 00", {digit, idx}); end
    checks++; if (tries !== 2'd3) begin errors++; $display("FAIL mid_rst_tries: got %0d, expected 3", tries); end
    pin_vec = 16'h3210;
    push_exp(EvOk, 16'h0, 2'd3);
    enter_pin(16'h3210);
    three_wrong();
    repeat (3) @(negedge clk);
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL mid_lock_on: got %b, expected 1", lock); end
    do_reset();
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL lock_rst: got %b, expected 0", lock); end
    checks++; if (tries !== 2'd3) begin errors++; $display("FAIL lock_rst_tries: got %0d, expected 3", tries); end
    checks++; if ({digit, idx} !== 6'd0) begin errors++; $display("FAIL lock_rst_pos: got %h, expected 00", {digit, idx}); end
    push_exp(EvOk, 16'h0, 2'd3);
    enter_pin(16'h3210);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_setup();
    test_correct();
    test_lockout();
    test_wrap_hold();
    test_simultaneous();
    test_mid_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
- Clocked, parametrised PIN-entry controller for the wallet front panel. Two buttons drive it: b_dir_i increments the current digit and b_esq_i selects it.
- Assembles DIGITS digits, then either compares them against the stored PIN or, in setup mode, emits them as the new PIN.
- Adds a wrong-attempt counter with timed lockout.
- Sits between the button inputs and the PIN storage/unlock logic.

Parameters:
- DIGITS, 4, number of PIN digits.
- DIGIT_W, 4, bits per digit.
- DIGIT_MAX, 9, largest digit value; increment wraps DIGIT_MAX->0. Must satisfy DIGIT_MAX < 2**DIGIT_W.
- MAX_TRIES, 3, consecutive wrong attempts before lockout (>=1).
- LOCK_CYCLES, 1000, lockout duration in clk_i cycles (>=1).

Ports:
- clk_i, in, 1, single clock. All logic is on the rising edge.
- rst_i, in, 1, synchronous, active-high reset.
- b_esq_i, in, 1, select/confirm button (level).
- b_dir_i, in, 1, increment button (level).
- setup_i, in, 1, 1 = the entered PIN becomes the new PIN; 0 = compare. Sampled in CHECK.
- pin_vec_i, in, DIGITS*DIGIT_W, stored PIN. Sampled in CHECK.
- digit_o, out, DIGIT_W, digit currently being edited.
- idx_o, out, $clog2(DIGITS), index of the digit being edited.
- new_pin_o, out, DIGITS*DIGIT_W, last PIN captured in setup mode.
- new_pin_vld_o, out, 1, one-cycle pulse when new_pin_o is updated.
- ok_o, out, 1, one-cycle pulse on a correct PIN.
- err_o, out, 1, one-cycle pulse on a wrong PIN.
- lock_o, out, 1, high while locked out.
- tries_left_o, out, $clog2(MAX_TRIES+1), remaining attempts.

Behaviour:
- Reset values:
  - state=ENTRY; digit_o=0; idx_o=0; entry buffer=0.
  - new_pin_o=0; all pulses=0; lock_o=0; tries_left_o=MAX_TRIES; lock counter=0.
- Button path, per button:
  - One register stage (sync), then a delayed copy (sync_d); edge = sync & ~sync_d.
  - If a button is first sampled high at edge k, its action is visible on the outputs at edge k+1.
  - A held button produces exactly one action; it must be released and pressed again for another.
- Digit order: the first digit entered goes to bits [DIGIT_W-1:0]; digit i goes to [i*DIGIT_W +: DIGIT_W]. Entering 0,1,2,3 gives 16'h3210.
- State ENTRY:
  - dir edge: digit_o <= (digit_o==DIGIT_MAX) ? 0 : digit_o+1.
  - esq edge: buffer[idx_o] <= digit_o; digit_o <= 0.
    - If idx_o==DIGITS-1: idx_o <= 0 and go to CHECK.
    - Otherwise idx_o <= idx_o+1.
  - esq and dir edges in the same cycle: select wins; the increment is discarded.
- State CHECK: lasts exactly one cycle, and button edges are ignored. The next state and outputs are registered at the following edge:
  - setup_i=1: new_pin_o <= buffer; new_pin_vld_o=1; tries_left_o <= MAX_TRIES; next state ENTRY.
  - Else, buffer==pin_vec_i: ok_o=1; tries_left_o <= MAX_TRIES; next state ENTRY.
  - Else, mismatch: err_o=1; tries_left_o decrements.
    - If the new value is 0: lock_o <= 1, load the lock counter with LOCK_CYCLES, next state LOCKED.
    - Otherwise next state ENTRY.
  - The buffer clears to 0 on leaving CHECK.
- State LOCKED:
  - Button edges are ignored and not queued; edge detection keeps running, so a button held through the lockout does not fire on exit.
  - The counter decrements every cycle. When it reaches 0: lock_o <= 0, tries_left_o <= MAX_TRIES, state ENTRY.
  - lock_o stays high for exactly LOCK_CYCLES cycles.
- Pulses ok_o, err_o and new_pin_vld_o are mutually exclusive and each lasts exactly one cycle.
- rst_i at any time, including mid-entry or during LOCKED, returns every output to its reset value at the next edge.
- Widths:
  - Digit arithmetic is modulo DIGIT_MAX+1 in DIGIT_W bits.
  - tries_left_o never underflows.
  - The lock counter is $clog2(LOCK_CYCLES+1) bits.

Decomposition:
- Package pin_pkg:
  - State enum {ENTRY, CHECK, LOCKED}.
  - Width helper functions for the idx, tries and lock-counter widths.
- Sub-module btn_edge (sync register plus rising-edge detect, output edge_o), instantiated once per button.

Test Plan:
- Setup: setup_i=1; press 0, dir-select 1, 2x dir-select 2, 3x dir-select 3 -> new_pin_vld_o single pulse, new_pin_o=16'h3210, ok_o=err_o=0.
- Correct PIN: setup_i=0, pin_vec_i=16'h3210, same sequence -> ok_o one-cycle pulse two edges after the last b_esq_i rise, tries_left_o=3, idx_o=0.
- Lockout: three entries of 0000 against 16'h3210 -> three err_o pulses and tries_left_o=2,1,0. lock_o then stays high for exactly LOCK_CYCLES cycles, and presses during that time have no effect. After lockout: tries_left_o=3, digit_o=0.
- Wrap and hold: 10 dir presses -> digit_o=0 (DIGIT_MAX=9). Holding b_dir_i for 20 cycles -> digit_o advances by exactly 1.
- Simultaneous press: b_esq_i and b_dir_i rise together with digit_o=2 -> 2 is stored, idx_o advances, digit_o=0 (no increment).
- Mid-operation reset: rst_i after two digits, or during LOCKED -> digit_o=0, idx_o=0, lock_o=0, tries_left_o=3. The next full correct entry gives ok_o.
